// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage 16-bit CPU: opcodes, hazard controller
// state encoding, PC source selects and the per-cycle pipeline control bundle.
package cpu_pkg;

    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [1:0] SEL_PC1  = 2'b00;
    localparam logic [1:0] SEL_CALL = 2'b01;
    localparam logic [1:0] SEL_EX   = 2'b10;

    typedef struct packed {
        logic       pc_we;
        logic       ifid_we;
        logic       ifid_flush;
        logic       idex_bubble;
        logic [1:0] redirect_sel;
    } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and run-state controller: load-use stalls, redirect flushes,
// CALL redirects in ID, the HLT drain sequence and stall/flush statistics.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_op,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [3:0]       ex_dst,
    input  logic             ex_redirect,
    input  logic             id_call,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       redirect_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    logic [1:0]    state_reg, state_next;
    logic [DW-1:0] drain_reg, drain_next;
    logic          load_use;
    logic          stall_inc;
    logic          flush_inc;
    ctrl_t         ctrl;

    // Register 0 is hardwired, so a LW targeting it never creates a dependency.
    always_comb begin
        load_use = ex_memread && ex_regwrite && (ex_dst != 4'd0) && id_valid &&
                   ((id_uses_rs && (id_rs == ex_dst)) ||
                    (id_uses_rt && (id_rt == ex_dst)));
    end

    always_comb begin
        state_next        = state_reg;
        drain_next        = drain_reg;
        stall_inc         = 1'b0;
        flush_inc         = 1'b0;
        ctrl.pc_we        = 1'b0;
        ctrl.ifid_we      = 1'b0;
        ctrl.ifid_flush   = 1'b0;
        ctrl.idex_bubble  = 1'b1;
        ctrl.redirect_sel = SEL_PC1;

        if (rst) begin
            ctrl.ifid_flush = 1'b1;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (ex_redirect) begin
                        ctrl.pc_we        = 1'b1;
                        ctrl.ifid_we      = 1'b1;
                        ctrl.ifid_flush   = 1'b1;
                        ctrl.redirect_sel = SEL_EX;
                        flush_inc         = 1'b1;
                    end else if (load_use) begin
                        stall_inc = 1'b1;
                    end else if (id_valid && (id_op == OP_HLT)) begin
                        state_next = ST_DRAIN;
                        drain_next = DW'(DRAIN_CYCLES - 1);
                    end else if (id_call) begin
                        ctrl.pc_we        = 1'b1;
                        ctrl.ifid_we      = 1'b1;
                        ctrl.ifid_flush   = 1'b1;
                        ctrl.idex_bubble  = 1'b0;
                        ctrl.redirect_sel = SEL_CALL;
                        flush_inc         = 1'b1;
                    end else begin
                        ctrl.pc_we       = 1'b1;
                        ctrl.ifid_we     = 1'b1;
                        ctrl.idex_bubble = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_reg == '0) begin
                        state_next = ST_HALTED;
                    end else begin
                        drain_next = drain_reg - 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_next = ST_HALTED;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
        end
    end

    assign pc_we        = ctrl.pc_we;
    assign ifid_we      = ctrl.ifid_we;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_bubble  = ctrl.idex_bubble;
    assign redirect_sel = ctrl.redirect_sel;
    assign halted       = (state_reg == ST_HALTED);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule
